// File: rtl/lbc_pkg.sv
// Shared types and default geometry for the ping-pong line buffer sequencer.
package lbc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_e;

    localparam int unsigned LBC_ADDR_W      = 10;
    localparam int unsigned LBC_LINE_PIXELS = 800;
    localparam int unsigned LBC_DECIM       = 2;
    localparam int unsigned LBC_LINE_REPEAT = 2;
    localparam int unsigned LBC_H_TOTAL     = 800;

    typedef logic buf_idx_t;

endpackage

// File: rtl/lbc_wr_addr_gen.sv
// Write-side address generator: decimation phase, write address, line activity
// and the single-cycle line-complete pulse.
module lbc_wr_addr_gen
    import lbc_pkg::*;
#(
    parameter int unsigned ADDR_W      = LBC_ADDR_W,
    parameter int unsigned LINE_PIXELS = LBC_LINE_PIXELS,
    parameter int unsigned DECIM       = LBC_DECIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start_i,
    input  logic              valid_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              line_done_o
);

    localparam int unsigned PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               active_q, active_d;
    logic               wr_en, line_done;

    always_comb begin
        phase_d   = phase_q;
        addr_d    = addr_q;
        active_d  = active_q;
        wr_en     = valid_i & (phase_q == '0) & active_q;
        line_done = wr_en & (addr_q == ADDR_W'(LINE_PIXELS - 1));

        // A line start always re-arms in place, including a restart mid-line.
        if (line_start_i) begin
            phase_d  = '0;
            addr_d   = '0;
            active_d = 1'b1;
        end else if (active_q && valid_i) begin
            phase_d = (phase_q == PHASE_W'(DECIM - 1)) ? '0 : phase_q + PHASE_W'(1);
            if (wr_en) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (line_done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            addr_q   <= '0;
            active_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            addr_q   <= addr_d;
            active_q <= active_d;
        end
    end

    assign wr_en_o     = wr_en;
    assign wr_addr_o   = addr_q;
    assign line_done_o = line_done;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line buffer sequencer between the PPU pixel stream and VGA scanout.
// Optional: define LBC_BLANK_ON_UNDERRUN_EN to blank VGA lines that replay on underrun.
module line_buffer_ctrl
    import lbc_pkg::*;
#(
    parameter int unsigned ADDR_W      = LBC_ADDR_W,
    parameter int unsigned LINE_PIXELS = LBC_LINE_PIXELS,
    parameter int unsigned DECIM       = LBC_DECIM,
    parameter int unsigned LINE_REPEAT = LBC_LINE_REPEAT,
    parameter int unsigned H_TOTAL     = LBC_H_TOTAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_line_start,
    input  logic              src_valid,
    input  logic              vga_line_start,
    input  logic              clr_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_buf,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_buf,
    output logic              vga_en,
    output logic              underrun,
    output logic              overrun,
    output logic              force_blank
);

    localparam int unsigned RPT_W = $clog2(LINE_REPEAT) + 1;

    state_e            state_q, state_d;
    buf_idx_t          wr_buf_q, wr_buf_d;
    buf_idx_t          rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [RPT_W-1:0]  repeat_q, repeat_d;
    logic              pending_q, pending_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              line_done;
    logic              take, und_set, ovr_set;

    lbc_wr_addr_gen #(
        .ADDR_W      (ADDR_W),
        .LINE_PIXELS (LINE_PIXELS),
        .DECIM       (DECIM)
    ) u_wr_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .line_start_i (src_line_start),
        .valid_i      (src_valid),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .line_done_o  (line_done)
    );

    always_comb begin
        state_d    = state_q;
        wr_buf_d   = wr_buf_q;
        rd_buf_d   = rd_buf_q;
        repeat_d   = repeat_q;
        pending_d  = pending_q;
        take       = 1'b0;
        und_set    = 1'b0;
        ovr_set    = 1'b0;

        unique case (state_q)
            S_IDLE:  if (src_line_start) state_d = S_PRIME;
            S_PRIME: if (line_done)      state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        rd_addr_d = vga_line_start ? '0
                  : (rd_addr_q == ADDR_W'(H_TOTAL - 1)) ? rd_addr_q
                  : rd_addr_q + ADDR_W'(1);

        if (vga_line_start && state_q == S_RUN) begin
            if (repeat_q == '0) begin
                if (pending_q) begin
                    take      = 1'b1;
                    rd_buf_d  = ~wr_buf_q;
                    pending_d = 1'b0;
                    repeat_d  = RPT_W'(LINE_REPEAT - 1);
                end else begin
                    und_set = 1'b1;
                end
            end else begin
                repeat_d = repeat_q - RPT_W'(1);
            end
        end

        // Completion is evaluated after the reader so a same-cycle line is kept pending.
        if (line_done) begin
            wr_buf_d  = ~wr_buf_q;
            pending_d = 1'b1;
            ovr_set   = pending_q;
        end

        underrun_d = und_set | (underrun_q & ~clr_err);
        overrun_d  = ovr_set | (overrun_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b1;
            rd_addr_q  <= '0;
            repeat_q   <= '0;
            pending_q  <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_buf_q   <= wr_buf_d;
            rd_buf_q   <= rd_buf_d;
            rd_addr_q  <= rd_addr_d;
            repeat_q   <= repeat_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef LBC_BLANK_ON_UNDERRUN_EN
    logic blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (und_set) begin
            blank_d = 1'b1;
        end else if (take) begin
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign force_blank = blank_q;
`else
    assign force_blank = 1'b0;
`endif

    assign wr_buf   = wr_buf_q;
    assign rd_buf   = rd_buf_q;
    assign rd_addr  = rd_addr_q;
    assign vga_en   = (state_q == S_RUN);
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl: startup, steady state,
// underrun, overrun, mid-line restart and reset mid-operation.
module tb_line_buffer_ctrl;

`ifdef LBC_BLANK_ON_UNDERRUN_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       src_line_start;
    logic       src_valid;
    logic       vga_line_start;
    logic       clr_err;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       wr_buf;
    logic [9:0] rd_addr;
    logic       rd_buf;
    logic       vga_en;
    logic       underrun;
    logic       overrun;
    logic       force_blank;

    int checks = 0;
    int errors = 0;

    line_buffer_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .src_line_start (src_line_start),
        .src_valid      (src_valid),
        .vga_line_start (vga_line_start),
        .clr_err        (clr_err),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_buf         (wr_buf),
        .rd_addr        (rd_addr),
        .rd_buf         (rd_buf),
        .vga_en         (vga_en),
        .underrun       (underrun),
        .overrun        (overrun),
        .force_blank    (force_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; observations are taken 1 ns later.
    task automatic step(input logic r, input logic s, input logic v, input logic l, input logic c);
        @(negedge clk);
        rst            = r;
        src_line_start = s;
        src_valid      = v;
        vga_line_start = l;
        clr_err        = c;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One 1600-cycle PPU line: start pulse at offset 0, src_valid at offsets 1..1599.
    task automatic run_line(input int v0, input int v1, input int exp_rd, input int clr_at,
                            input bit prime, input bit steady);
        int nwr = 0;
        for (int o = 0; o < 1600; o++) begin
            step(1'b0, o == 0, o != 0, (o == v0) || (o == v1), o == clr_at);
            if (wr_en) begin
                chk("wr_addr_seq", 32'(wr_addr), nwr);
                nwr++;
            end
            if (exp_rd >= 0 && (o == 1 || o == 801)) begin
                chk("rd_buf_steady", 32'(rd_buf), exp_rd);
                chk("rd_opposite_wr", 32'(rd_buf ^ wr_buf), 1);
            end
            if (prime && o == 1599) begin
                chk("prime_vga_en_low", 32'(vga_en), 0);
                chk("prime_wr_buf_last", 32'(wr_buf), 0);
            end
            if (steady && o == 1599) begin
                chk("steady_underrun", 32'(underrun), 0);
                chk("steady_overrun", 32'(overrun), 0);
            end
        end
        chk("wr_count_line", nwr, 800);
    endtask

    initial begin
        int nw;
        rst = 1'b1; src_line_start = 1'b0; src_valid = 1'b0;
        vga_line_start = 1'b0; clr_err = 1'b0;

        // Reset values
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_buf", 32'(wr_buf), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_rd_buf", 32'(rd_buf), 1);
        chk("rst_vga_en", 32'(vga_en), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_force_blank", 32'(force_blank), 0);

        // Startup prime, with a vga_line_start during S_PRIME that must be ignored
        run_line(-1, 100, -1, -1, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("start_vga_en", 32'(vga_en), 1);
        chk("start_wr_buf", 32'(wr_buf), 1);
        chk("start_rd_buf", 32'(rd_buf), 1);
        chk("start_underrun", 32'(underrun), 0);
        chk("start_overrun", 32'(overrun), 0);

        // Steady state: ten lines, VGA lines at offsets 0 and 800
        for (int k = 1; k <= 10; k++) begin
            run_line(0, 800, (k % 2 == 1) ? 0 : 1, -1, 0, 1);
        end

        // Underrun: source stalls for one PPU line
        for (int o = 0; o < 1600; o++) begin
            step(0, 0, 0, (o == 0) || (o == 800), 0);
            if (o == 1) chk("stall_take_rd_buf", 32'(rd_buf), 0);
        end
        step(0, 0, 0, 1, 0);
        chk("und_before", 32'(underrun), 0);
        step(0, 0, 0, 0, 0);
        chk("und_set", 32'(underrun), 1);
        chk("und_rd_buf_hold", 32'(rd_buf), 0);
        chk("und_force_blank", 32'(force_blank), 32'(BLANK));
        chk("und_rd_addr", 32'(rd_addr), 0);
        step(0, 0, 0, 0, 1);
        chk("und_clr_pre", 32'(underrun), 1);
        step(0, 0, 0, 0, 0);
        chk("und_clr", 32'(underrun), 0);
        chk("und_blank_held", 32'(force_blank), 32'(BLANK));

        // Recovery: a line written with no VGA pulses, then a fresh take
        run_line(-1, -1, -1, -1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rd_addr_saturate", 32'(rd_addr), 799);
        chk("recov_wr_buf", 32'(wr_buf), 0);
        chk("recov_overrun", 32'(overrun), 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("recov_rd_buf", 32'(rd_buf), 1);
        chk("recov_force_blank", 32'(force_blank), 0);
        chk("recov_underrun", 32'(underrun), 0);
        chk("recov_rd_addr", 32'(rd_addr), 0);

        // Overrun: two completions without a VGA line start
        run_line(-1, -1, -1, -1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr_first_wr_buf", 32'(wr_buf), 1);
        chk("ovr_first_flag", 32'(overrun), 0);
        run_line(-1, -1, -1, -1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_wr_buf_twice", 32'(wr_buf), 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ovr_clr", 32'(overrun), 0);
        // clr_err in the completion cycle: the set wins
        run_line(-1, -1, -1, 1599, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr_set_wins", 32'(overrun), 1);
        chk("ovr_third_wr_buf", 32'(wr_buf), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("ovr_clr2", 32'(overrun), 0);

        // Mid-line restart after 300 writes
        nw = 0;
        step(0, 1, 0, 0, 0);
        for (int o = 1; o < 600; o++) begin
            step(0, 0, 1, 0, 0);
            if (wr_en) begin
                chk("mid_wr_addr", 32'(wr_addr), nw);
                nw++;
            end
        end
        chk("mid_count_300", nw, 300);
        step(0, 0, 0, 0, 0);
        chk("mid_wr_addr_300", 32'(wr_addr), 300);
        chk("mid_wr_buf", 32'(wr_buf), 1);
        run_line(-1, -1, -1, -1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mid_single_swap", 32'(wr_buf), 0);
        chk("mid_overrun", 32'(overrun), 1);

        // Reset at write 400 in S_RUN
        nw = 0;
        step(0, 1, 0, 0, 0);
        for (int o = 1; o < 800; o++) begin
            step(0, 0, 1, 0, 0);
            if (wr_en) nw++;
        end
        chk("rr_count_400", nw, 400);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rr_wr_addr", 32'(wr_addr), 0);
        chk("rr_wr_buf", 32'(wr_buf), 0);
        chk("rr_rd_addr", 32'(rd_addr), 0);
        chk("rr_rd_buf", 32'(rd_buf), 1);
        chk("rr_vga_en", 32'(vga_en), 0);
        chk("rr_underrun", 32'(underrun), 0);
        chk("rr_overrun", 32'(overrun), 0);
        chk("rr_force_blank", 32'(force_blank), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0);
            chk("rr_no_write_idle", 32'(wr_en), 0);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("rr_idle_rd_buf", 32'(rd_buf), 1);
        chk("rr_idle_underrun", 32'(underrun), 0);
        chk("rr_idle_vga_en", 32'(vga_en), 0);
        run_line(-1, -1, -1, -1, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("rr_reprime_vga_en", 32'(vga_en), 1);
        chk("rr_reprime_wr_buf", 32'(wr_buf), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for the ping-pong RGB line buffers between the PPU pixel stream and the 640x480 VGA/TMDS scanout.
- Generates write address/enable with 2:1 decimation, buffer ownership swap, read buffer select and read address.
- Line repeat: each PPU line is shown on LINE_REPEAT VGA lines. Produces vga_en once the first line is primed.
- Tracks underrun/overrun so the display pipeline starts and stays line-locked to the PPU.

Parameters:
- ADDR_W, 10, line buffer address width.
- LINE_PIXELS, 800, decimated pixels written per PPU line (write addresses 0..LINE_PIXELS-1).
- DECIM, 2, src_valid beats per written pixel; the first beat of each group is written.
- LINE_REPEAT, 2, VGA lines displayed per completed PPU line.
- H_TOTAL, 800, read-address span per VGA line.

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- src_line_start  in  1  one-cycle pulse, start of PPU line
- src_valid  in  1  one PPU pixel present this cycle
- vga_line_start  in  1  one-cycle pulse, h_cnt wrap to 0
- clr_err  in  1  clears sticky error flags
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  write address
- wr_buf  out  1  buffer being written (0/1)
- rd_addr  out  ADDR_W  read address
- rd_buf  out  1  buffer being displayed
- vga_en  out  1  timing generator enable
- underrun  out  1  sticky
- overrun  out  1  sticky
- force_blank  out  1  see Optional Feature

Behaviour:
- Reset: state=S_IDLE; wr_en=0, wr_addr=0, wr_buf=0, rd_addr=0, rd_buf=1, vga_en=0, underrun=0, overrun=0, force_blank=0, pending=0, repeat_cnt=0, phase=0.
- State S_IDLE: wait for src_line_start, then go to S_PRIME with wr_addr=0 and phase=0.
- State S_PRIME: write the first line. On line completion, go to S_RUN. vga_en rises the cycle after completion and never falls until rst.
- State S_RUN: steady state; writing and reading run concurrently.
- Write path:
  - wr_en = src_valid & (phase==0) & line_active, combinational from registered state.
  - phase advances mod DECIM on each src_valid.
  - wr_addr increments after each write.
  - Line completes on the write at LINE_PIXELS-1: line_active clears, wr_buf toggles next cycle, pending sets.
  - src_valid after completion is ignored until the next src_line_start.
- src_line_start mid-line (line_active=1): restart wr_addr=0 and phase=0 in the same buffer; no swap, no pending.
- Overrun: line completion while pending=1 sets overrun. Swap still occurs, so the newest line wins.
- Read path:
  - rd_addr resets to 0 on vga_line_start, else increments, saturating at H_TOTAL-1.
  - On vga_line_start with repeat_cnt==0:
    - pending=1: rd_buf <= ~wr_buf, pending clears, repeat_cnt <= LINE_REPEAT-1.
    - pending=0: rd_buf holds (line replay) and underrun sets.
  - Otherwise repeat_cnt decrements.
- Simultaneous line completion and vga_line_start: the reader samples pre-completion pending (registered). The new line waits for the next vga_line_start.
- vga_line_start in S_IDLE/S_PRIME is ignored; rd_addr still counts.
- clr_err clears underrun and overrun; a same-cycle set wins.
- rst mid-line returns all state to reset values within one cycle; partial lines are discarded.
- Widths: all counters wrap only as stated; repeat_cnt is $clog2(LINE_REPEAT)+1 bits.

Optional Feature:
- Macro: LBC_BLANK_ON_UNDERRUN_EN.
- Defined: force_blank=1 for the whole VGA line following any vga_line_start that registered an underrun. It is set on that pulse, cleared at the next vga_line_start that takes a fresh line.
- Undefined: force_blank is tied 0; underrun replays the previous line.

Decomposition:
- Package lbc_pkg holds: state enum (S_IDLE, S_PRIME, S_RUN), default constants (LINE_PIXELS, DECIM, LINE_REPEAT, H_TOTAL), and the buffer index type.
- One natural sub-module, lbc_wr_addr_gen: phase counter, wr_addr, line_active, and the line-complete pulse.
- Swap/pending/read logic stays in the top.

Test Plan:
- Startup: rst, src_line_start, then 1600 src_valid -> wr_en exactly 800 times at addresses 0..799, wr_buf 0->1 after the last, vga_en=1 on the next cycle, no errors.
- Steady state: PPU line every 1600 clocks, vga_line_start every 800 -> rd_buf toggles every 2nd vga_line_start, always opposite wr_buf; underrun/overrun stay 0 over 10 lines.
- Underrun: stall src 1 line -> underrun=1 at the 3rd vga_line_start; rd_buf unchanged; force_blank=1 with the macro, 0 without.
- Overrun: two lines complete without vga_line_start -> overrun=1, wr_buf toggled twice; clr_err -> 0 next cycle.
- Mid-line restart: src_line_start after 300 writes -> wr_addr returns to 0, wr_buf unchanged, line completes after 800 further writes.
- Reset mid-operation: rst at write 400 in S_RUN -> all outputs return to reset values; a fresh S_PRIME is required before vga_en.
